branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters. It predicts the next fetch target in IF and resolves prediction accuracy from ID branch outcomes. ID drives mispredict/redirect back to the PC stage and holds the running accuracy statistics. It supersedes the purely combinational ID-stage branch decision by adding per-branch history, so fetch can steer before resolution.

## Interface
- ENTRIES, 64: BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES).
- TAG_W, 8: stored tag bits; IDX_W+TAG_W+2 ≤ 32.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- if_pc  in  32  PC of the instruction being fetched (IF).
- pred_taken  out  1  IF lookup hit with counter[1]=1.
- pred_target  out  32  stored target if pred_taken, else if_pc+8.
- upd_valid  in  1  ID has a resolved branch/jump this cycle.
- upd_pc  in  32  PC of the resolved branch instruction.
- upd_is_cond  in  1  1 = conditional branch; 0 = jump (j/jal/jr/jalr).
- upd_taken  in  1  actual direction (always 1 for jumps).
- upd_target  in  32  actual taken target.
- upd_pred_taken  in  1  pred_taken carried down from IF for this instruction.
- upd_pred_target  in  32  pred_target carried down from IF.
- mispredict  out  1  ID resolution differs from IF prediction.
- redirect_pc  out  32  correct next-after-delay-slot PC.
- btb_flush  in  1  invalidate all entries.
- stat_clr  in  1  zero statistics counters.
- branch_count  out  32  resolved branches since reset/clear.
- mispred_count  out  32  mispredictions since reset/clear.

## Operation
- Address split: index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry: valid, tag, target[31:0], ctr[1:0].
- Lookup: combinational on if_pc. hit = valid && tag match. pred_taken = hit && ctr[1].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Resolution, combinational, when upd_valid:
  - actual = upd_taken ? upd_target : upd_pc+8.
  - predicted = upd_pred_taken ? upd_pred_target : upd_pc+8.
  - mispredict = upd_valid && (actual != predicted).
  - redirect_pc = actual.
  - When upd_valid=0: mispredict=0 and redirect_pc = upd_pc+8.
- Update on clock edge when upd_valid and not btb_flush:
  - Hit, cond: ctr saturating +1 if taken, −1 if not; at 11/00 it holds. Target is overwritten only when taken.
  - Hit, jump: ctr←11, target←upd_target.
  - Miss, taken: allocate, replacing any occupant. Sets valid, tag, target; ctr←10 if cond, 11 if jump.
  - Miss, not taken: no change.
- Statistics:
  - When upd_valid: branch_count+1, and mispred_count+1 if mispredict.
  - 32-bit wrap at 0xFFFFFFFF→0.
  - stat_clr zeroes both and overrides the same-cycle increment.
- btb_flush clears all valid bits in one cycle and suppresses the same-cycle update. It does not touch statistics.

## Timing
- Reset (rst_n=0 at edge): all valid=0, all ctr=01, branch_count=0, mispred_count=0.
- During and after reset, pred_taken=0 and pred_target=if_pc+8. mispredict/redirect_pc stay combinational from inputs.
- Target and tag arrays need not be reset.
- Prediction latency is 0 cycles (combinational from registered arrays). An update becomes visible to lookups on the cycle after its edge.
- No write-to-read bypass: a same-cycle lookup of the index being updated returns the pre-update entry.
- mispredict/redirect_pc are valid in the same cycle as upd_valid. The PC stage samples them on that edge.
- Priority per edge: rst_n=0 > btb_flush > update. Statistics: rst_n=0 > stat_clr > increment.

## Test plan
- Reset, then if_pc=0x00400000 → pred_taken=0, pred_target=0x00400008, branch_count=0, mispred_count=0.
- Allocate and predict:
  - Stimulus: upd_valid, upd_pc=0x00400010, cond, taken, target 0x00400100, upd_pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x00400100.
  - Next cycle with if_pc=0x00400010: pred_taken=1, pred_target=0x00400100, branch_count=1, mispred_count=1.
- Hysteresis: from the entry above (ctr 10), resolve not-taken with upd_pred_taken=1 and upd_pred_target=0x00400100.
  - Same cycle: mispredict=1, redirect_pc=0x00400018.
  - Lookup of 0x00400010 then gives pred_taken=0, pred_target=0x00400018 (ctr 01).
  - A second not-taken sets ctr 00; a third stays 00.
- Alias: taken update at 0x00400110 (same index 4, different tag) → lookup 0x00400010 misses (pred_target=0x00400018); lookup 0x00400110 hits.
- Jump:
  - Stimulus: upd_is_cond=0, upd_pc=0x00400200, target 0x00401000, upd_pred_taken=1, upd_pred_target=0x00401000.
  - Response: mispredict=0, redirect_pc=0x00401000. The entry then predicts taken; ctr stays 11 after repeated jumps.
- Simultaneous: btb_flush=1 and stat_clr=1 with a taken upd_valid → next cycle all lookups miss, branch_count=0, mispred_count=0. Then pulse rst_n=0 mid-run and verify all reset values.

Source files
------------

// File: rtl/branch_predictor_if.sv
// branch_predictor_if
//   Groups the fetch-lookup, ID-resolution, maintenance and statistics
//   signals of the branch predictor.
//
//   Handshake: upd_valid is a single-cycle qualifier with no ready.
//   The predictor accepts every resolution on the rising edge where
//   upd_valid is high. All upd_* fields are meaningful only in that cycle.
//   There is no backpressure path.
//
//   master : the pipeline side (drives if_pc, upd_*, btb_flush, stat_clr)
//   slave  : the predictor (drives pred_*, mispredict, redirect_pc, counts)
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    logic        btb_flush;
    logic        stat_clr;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, btb_flush, stat_clr,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispred_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, btb_flush, stat_clr,
        output pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. It does three things:
//     - predicts the next fetch target for if_pc with zero latency;
//     - resolves the ID-stage outcome against the prediction carried down
//       from IF and produces the mispredict and redirect signals;
//     - keeps running counts of branches and mispredictions.
//
//   Ports:
//     clk    : clock; all state changes on the rising edge
//     rst_n  : synchronous active-low reset
//     bp     : branch_predictor_if.slave
//                if_pc -> pred_taken / pred_target
//                upd_* -> mispredict / redirect_pc
//                btb_flush, stat_clr -> branch_count / mispred_count
//
//   Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//   There is no bypass from the write port to the read port. A lookup of an
//   index that is being updated in the same cycle sees the old entry.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [31:0]       branch_count_q;
    logic [31:0]       mispred_count_q;

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign if_tag = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // Gating with rst_n keeps the prediction quiet while reset is still
    // asserted and the arrays have not yet been cleared.
    assign bp.pred_taken  = rst_n && if_hit && ctr_q[if_idx][1];
    assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : bp.if_pc + 32'd8;

    // ---------------- ID resolution ----------------
    logic [31:0] fall_through;
    logic [31:0] actual_pc;
    logic [31:0] predicted_pc;

    assign fall_through   = bp.upd_pc + 32'd8;
    assign actual_pc      = bp.upd_taken ? bp.upd_target : fall_through;
    assign predicted_pc   = bp.upd_pred_taken ? bp.upd_pred_target : fall_through;
    assign bp.mispredict  = bp.upd_valid && (actual_pc != predicted_pc);
    assign bp.redirect_pc = bp.upd_valid ? actual_pc : fall_through;

    // ---------------- update decode ----------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_new;
    logic             ctr_wr;
    logic             tgt_wr;
    logic             alloc;

    assign upd_idx = bp.upd_pc[IDX_W+1:2];
    assign upd_tag = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign ctr_cur = ctr_q[upd_idx];

    always_comb begin
        ctr_new = ctr_cur;
        ctr_wr  = 1'b0;
        tgt_wr  = 1'b0;
        alloc   = 1'b0;
        if (bp.upd_valid && !bp.btb_flush) begin
            if (upd_hit) begin
                ctr_wr = 1'b1;
                if (bp.upd_is_cond) begin
                    if (bp.upd_taken) begin
                        ctr_new = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
                        tgt_wr  = 1'b1;
                    end else begin
                        ctr_new = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
                    end
                end else begin
                    ctr_new = 2'b11;
                    tgt_wr  = 1'b1;
                end
            end else if (bp.upd_taken) begin
                // A miss that is taken replaces whatever occupies the index.
                alloc   = 1'b1;
                ctr_wr  = 1'b1;
                tgt_wr  = 1'b1;
                ctr_new = bp.upd_is_cond ? 2'b10 : 2'b11;
            end
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (bp.btb_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (alloc)  valid_q[upd_idx] <= 1'b1;
            if (ctr_wr) ctr_q[upd_idx]   <= ctr_new;
        end
    end

    // The tag and target arrays carry no reset. Their contents are only
    // observed through a valid entry.
    always_ff @(posedge clk) begin
        if (rst_n && tgt_wr) target_q[upd_idx] <= bp.upd_target;
        if (rst_n && alloc)  tag_q[upd_idx]    <= upd_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bp.stat_clr) begin
            branch_count_q  <= 32'd0;
            mispred_count_q <= 32'd0;
        end else if (bp.upd_valid) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (bp.mispredict) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign bp.branch_count  = branch_count_q;
    assign bp.mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;
    localparam int TAG_W   = 8;

    logic clk = 1'b0;
    logic rst_n;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q  [$];
    string       name_q [$];

    // Independent model of the predictor behaviour.
    logic              m_valid  [ENTRIES];
    logic [TAG_W-1:0]  m_tag    [ENTRIES];
    logic [31:0]       m_target [ENTRIES];
    logic [1:0]        m_ctr    [ENTRIES];
    logic [31:0]       m_bc;
    logic [31:0]       m_mc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] val);
        name_q.push_back(name);
        exp_q.push_back(val);
    endtask

    task automatic exp_lookup(input logic pt, input logic [31:0] tgt);
        push_exp("pred_taken", {31'd0, pt});
        push_exp("pred_target", tgt);
    endtask

    task automatic exp_resolve(input logic mp, input logic [31:0] rpc);
        push_exp("mispredict", {31'd0, mp});
        push_exp("redirect_pc", rpc);
    endtask

    task automatic exp_stats(input logic [31:0] bc, input logic [31:0] mc);
        push_exp("branch_count", bc);
        push_exp("mispred_count", mc);
    endtask

    function automatic logic [31:0] get_obs(input string name);
        if (name == "pred_taken")         return {31'd0, bp_if.pred_taken};
        else if (name == "pred_target")   return bp_if.pred_target;
        else if (name == "mispredict")    return {31'd0, bp_if.mispredict};
        else if (name == "redirect_pc")   return bp_if.redirect_pc;
        else if (name == "branch_count")  return bp_if.branch_count;
        else if (name == "mispred_count") return bp_if.mispred_count;
        return 32'hdead_beef;
    endfunction

    // ---------------- model ----------------
    task automatic m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
        int idx;
        logic [TAG_W-1:0] tg;
        idx = int'(pc[IDX_W+1:2]);
        tg  = pc[IDX_W+TAG_W+1:IDX_W+2];
        pt  = rst_n && m_valid[idx] && (m_tag[idx] == tg) && m_ctr[idx][1];
        tgt = pt ? m_target[idx] : pc + 32'd8;
    endtask

    task automatic m_resolve(output logic mp, output logic [31:0] rpc);
        logic [31:0] act, pred, ft;
        ft   = bp_if.upd_pc + 32'd8;
        act  = bp_if.upd_taken ? bp_if.upd_target : ft;
        pred = bp_if.upd_pred_taken ? bp_if.upd_pred_target : ft;
        mp   = bp_if.upd_valid && (act != pred);
        rpc  = bp_if.upd_valid ? act : ft;
    endtask

    task automatic model_edge();
        int idx;
        logic [TAG_W-1:0] tg;
        logic mp;
        logic [31:0] rpc;
        m_resolve(mp, rpc);
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 2'b01;
            end
            m_bc = 0;
            m_mc = 0;
            return;
        end
        if (bp_if.stat_clr) begin
            m_bc = 0;
            m_mc = 0;
        end else if (bp_if.upd_valid) begin
            m_bc = m_bc + 1;
            if (mp) m_mc = m_mc + 1;
        end
        if (bp_if.btb_flush) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (bp_if.upd_valid) begin
            idx = int'(bp_if.upd_pc[IDX_W+1:2]);
            tg  = bp_if.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
            if (m_valid[idx] && m_tag[idx] == tg) begin
                if (!bp_if.upd_is_cond) begin
                    m_ctr[idx]    = 2'b11;
                    m_target[idx] = bp_if.upd_target;
                end else if (bp_if.upd_taken) begin
                    if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
                    m_target[idx] = bp_if.upd_target;
                end else if (m_ctr[idx] != 2'b00) begin
                    m_ctr[idx] = m_ctr[idx] - 2'd1;
                end
            end else if (bp_if.upd_taken) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = tg;
                m_target[idx] = bp_if.upd_target;
                m_ctr[idx]    = bp_if.upd_is_cond ? 2'b10 : 2'b11;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_upd(input logic v, input logic [31:0] pc, input logic cond,
                           input logic taken, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt);
        bp_if.upd_valid       = v;
        bp_if.upd_pc          = pc;
        bp_if.upd_is_cond     = cond;
        bp_if.upd_taken       = taken;
        bp_if.upd_target      = tgt;
        bp_if.upd_pred_taken  = pt;
        bp_if.upd_pred_target = ptgt;
    endtask

    task automatic idle_upd();
        set_upd(1'b0, 32'h0040_0000, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        bp_if.btb_flush = 1'b0;
        bp_if.stat_clr  = 1'b0;
    endtask

    // Inputs are stable from #1 after a rising edge; outputs are compared
    // on the falling edge, then the model takes the same rising edge.
    task automatic run_cycle();
        string       nm;
        logic [31:0] ev;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front();
            ev = exp_q.pop_front();
            check_val(nm, get_obs(nm), ev);
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_cycle(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        idle_upd();
        bp_if.if_pc = pc;
        exp_lookup(pt, tgt);
        run_cycle();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] pool_pc;
    logic        r_pt, r_mp;
    logic [31:0] r_ptgt, r_rpc;

    function automatic logic [31:0] pick_pc();
        logic [31:0] idx, tg;
        idx = 32'($urandom_range(0, 7));
        tg  = 32'($urandom_range(0, 2));
        return 32'h0040_0000 | (idx << 2) | (tg << 8);
    endfunction

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_ctr[i]    = 2'b01;
            m_tag[i]    = '0;
            m_target[i] = '0;
        end
        m_bc = 0;
        m_mc = 0;

        rst_n = 1'b0;
        idle_upd();
        bp_if.if_pc = 32'h0040_0000;

        // reset: prediction quiet while reset is held and after release
        exp_lookup(1'b0, 32'h0040_0008);
        run_cycle();
        run_cycle();
        rst_n = 1'b1;
        exp_lookup(1'b0, 32'h0040_0008);
        exp_stats(32'd0, 32'd0);
        run_cycle();

        // allocate a taken conditional branch
        set_upd(1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0018);
        exp_resolve(1'b1, 32'h0040_0100);
        run_cycle();
        idle_upd();
        bp_if.if_pc = 32'h0040_0010;
        exp_lookup(1'b1, 32'h0040_0100);
        exp_stats(32'd1, 32'd1);
        run_cycle();

        // hysteresis: 10 -> 01 -> 00 -> 00, then two takens 01 -> 10
        set_upd(1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
        exp_resolve(1'b1, 32'h0040_0018);
        run_cycle();
        lookup_cycle(32'h0040_0010, 1'b0, 32'h0040_0018);
        exp_stats(32'd2, 32'd2);
        run_cycle();
        for (int k = 0; k < 2; k++) begin
            set_upd(1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0018);
            exp_resolve(1'b0, 32'h0040_0018);
            run_cycle();
        end
        set_upd(1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0018);
        exp_resolve(1'b1, 32'h0040_0100);
        run_cycle();
        lookup_cycle(32'h0040_0010, 1'b0, 32'h0040_0018);
        set_upd(1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0018);
        run_cycle();
        lookup_cycle(32'h0040_0010, 1'b1, 32'h0040_0100);
        exp_stats(32'd6, 32'd4);
        run_cycle();

        // alias: same index 4, different tag replaces the occupant
        set_upd(1'b1, 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0118);
        exp_resolve(1'b1, 32'h0040_0300);
        run_cycle();
        lookup_cycle(32'h0040_0010, 1'b0, 32'h0040_0018);
        lookup_cycle(32'h0040_0110, 1'b1, 32'h0040_0300);

        // jumps: correct prediction, counter pinned at 11
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, 32'h0040_0200, 1'b0, 1'b1, 32'h0040_1000, 1'b1, 32'h0040_1000);
            exp_resolve(1'b0, 32'h0040_1000);
            run_cycle();
        end
        lookup_cycle(32'h0040_0200, 1'b1, 32'h0040_1000);
        set_upd(1'b1, 32'h0040_0200, 1'b1, 1'b0, 32'h0040_1000, 1'b1, 32'h0040_1000);
        exp_resolve(1'b1, 32'h0040_0208);
        run_cycle();
        lookup_cycle(32'h0040_0200, 1'b1, 32'h0040_1000);

        // flush + clear with a same-cycle taken update
        set_upd(1'b1, 32'h0040_0400, 1'b1, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0408);
        bp_if.btb_flush = 1'b1;
        bp_if.stat_clr  = 1'b1;
        exp_resolve(1'b1, 32'h0040_0500);
        run_cycle();
        lookup_cycle(32'h0040_0110, 1'b0, 32'h0040_0118);
        exp_stats(32'd0, 32'd0);
        run_cycle();
        lookup_cycle(32'h0040_0200, 1'b0, 32'h0040_0208);
        lookup_cycle(32'h0040_0400, 1'b0, 32'h0040_0408);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            pool_pc = pick_pc();
            m_lookup(pool_pc, r_pt, r_ptgt);
            if ($urandom_range(0, 9) == 0) r_pt = ~r_pt;
            set_upd(1'($urandom_range(0, 3) != 0), pool_pc, 1'($urandom_range(0, 3) != 0),
                    1'b1, 32'h0041_0000 + 32'($urandom_range(0, 3) << 4), r_pt, r_ptgt);
            if (bp_if.upd_is_cond) bp_if.upd_taken = 1'($urandom_range(0, 1));
            bp_if.btb_flush = ($urandom_range(0, 29) == 0);
            bp_if.stat_clr  = ($urandom_range(0, 29) == 0);
            bp_if.if_pc     = pick_pc();
            m_resolve(r_mp, r_rpc);
            exp_resolve(r_mp, r_rpc);
            m_lookup(bp_if.if_pc, r_pt, r_ptgt);
            exp_lookup(r_pt, r_ptgt);
            exp_stats(m_bc, m_mc);
            run_cycle();
        end

        // mid-run reset with a taken update that must be ignored
        rst_n = 1'b0;
        set_upd(1'b1, 32'h0040_0004, 1'b1, 1'b1, 32'h0040_0700, 1'b0, 32'h0040_000c);
        bp_if.if_pc = 32'h0040_0004;
        exp_lookup(1'b0, 32'h0040_000c);
        run_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pool_pc = 32'h0040_0000 | (32'(k) << 2);
            lookup_cycle(pool_pc, 1'b0, pool_pc + 32'd8);
            exp_stats(32'd0, 32'd0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
